pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 37, meaning payload bits (16 mem data + 16 ALU result + 4 rd + 1 ret_future).
REQ-002 SHALL have parameter CNT_W, default 16, meaning statistics counter width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset, synchronous and active-low.
REQ-005 SHALL have port flush, input, 1, meaning discard all held and incoming payloads.
REQ-006 SHALL have port in_valid, input, 1, meaning upstream payload present.
REQ-007 SHALL have port in_ready, output, 1, meaning stage accepts a payload this cycle.
REQ-008 SHALL have port in_data, input, WIDTH, meaning upstream payload.
REQ-009 SHALL have port out_valid, output, 1, meaning out_data is a live payload.
REQ-010 SHALL have port out_ready, input, 1, meaning downstream consumes out_data this cycle.
REQ-011 SHALL have port out_data, output, WIDTH, meaning payload to next stage.
REQ-012 SHALL have ports stall_cnt and bubble_cnt, output, CNT_W each, meaning statistics per REQ-027.

Function
REQ-013 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-014 SHALL hold two entries, main (drives out_data) and skid, tracked by states EMPTY, ONE, FULL.
REQ-015 SHALL, in EMPTY, move to ONE with main <= in_data on in_fire; otherwise stay EMPTY.
REQ-016 SHALL, in ONE: in_fire & out_fire -> ONE, main <= in_data; in_fire only -> FULL, skid <= in_data; out_fire only -> EMPTY; neither -> ONE.
REQ-017 SHALL, in FULL, move to ONE with main <= skid on out_fire; otherwise stay FULL.
REQ-018 SHALL drive out_valid = 1 exactly in ONE and FULL, and in_ready = 1 exactly in EMPTY and ONE.
REQ-019 SHALL have out_valid, out_data and in_ready come from registers only: no combinational path from in_* to out_*, or from out_ready to in_ready.
REQ-020 SHALL give one-cycle latency: a payload accepted at edge N appears on out_data after edge N when the stage was EMPTY or main was consumed at N.
REQ-021 SHALL preserve order and never drop or duplicate a payload; sustained in_valid and out_ready gives one transfer per cycle.
REQ-022 SHALL keep out_data stable while out_valid & !out_ready.
REQ-023 SHALL, when flush = 1, enter EMPTY at the next edge, ignoring same-cycle in_fire and out_fire; flush has priority over all transitions.
REQ-024 SHALL leave data registers unchanged when no entry is written (no X, no clearing on flush).

Reset
REQ-025 SHALL, at a rising edge with rst_n = 0, set state EMPTY, main = 0, skid = 0, stall_cnt = 0 and bubble_cnt = 0; out_valid = 0, out_data = 0 and in_ready = 1 follow from this state.
REQ-026 SHALL give reset priority over flush and handshakes, including a reset while FULL, which discards both entries.

Configuration
REQ-027 SHALL, with macro PIPE_STAGE_STATS_EN defined, increment stall_cnt each cycle out_valid & !out_ready and bubble_cnt each cycle !out_valid (after reset), each saturating at 2^CNT_W-1; flush does not clear them.
REQ-028 SHALL, without PIPE_STAGE_STATS_EN, keep both ports present, tie them to 0 and instantiate no counter logic.

Structure
REQ-029 SHALL take state enum pipe_state_t {EMPTY, ONE, FULL} and field widths (DATA_W = 16, REG_W = 4) from shared package pipe_pkg.
REQ-030 SHALL implement each statistic with one sub-module sat_counter (enable, synchronous active-low clear, saturate), instantiated only under PIPE_STAGE_STATS_EN.

Verification
REQ-031 SHALL verify reset: hold rst_n = 0 for 2 edges while driving in_valid = 1 and in_data = 37'h1_2345_6789 -> out_valid = 0, out_data = 0, in_ready = 1, counters = 0.
REQ-032 SHALL verify streaming: out_ready = 1 and payloads 1..8 on consecutive cycles -> out_data = 1..8 on consecutive cycles, one cycle behind input, in_ready always 1.
REQ-033 SHALL verify backpressure: send A = 0xA and B = 0xB with out_ready = 0 -> FULL, in_ready = 0, out_data held at 0xA; then raise out_ready -> 0xA, then 0xB, no loss.
REQ-034 SHALL verify flush while FULL with in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, and the flushed and incoming payloads never appear.
REQ-035 SHALL verify stats with PIPE_STAGE_STATS_EN and CNT_W = 4: 20 stall cycles -> stall_cnt = 15 (saturated); the same test without the macro -> both counters read 0.
REQ-036 SHALL verify simultaneous events in ONE: in_fire and out_fire on the same cycle -> stays ONE with the new payload on out_data next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by the pipeline stage register and its
// helpers.
//   pipe_state_t : occupancy of the two-entry stage (EMPTY, ONE, FULL)
//   DATA_W       : width of the memory-data and ALU-result fields
//   REG_W        : width of the destination register index
//   PAYLOAD_W    : default payload width (mem data + ALU result + rd + ret_future)
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    localparam int DATA_W    = 16;
    localparam int REG_W     = 4;
    localparam int PAYLOAD_W = 2 * DATA_W + REG_W + 1;

endpackage : pipe_pkg

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at its all-ones value.
//   clk   : clock, counts on the rising edge
//   clr_n : synchronous active-low clear (wins over en)
//   en    : count enable for this cycle
//   count : current value, W bits
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule : sat_counter

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: fully registered valid/ready pipeline stage with a skid
// entry, so in_ready never depends combinationally on out_ready.
//   clk, rst_n            : clock and synchronous active-low reset
//   flush                 : drop held and incoming payloads, go EMPTY
//   in_valid/in_ready/in_data    : upstream handshake and payload
//   out_valid/out_ready/out_data : downstream handshake and payload
//   stall_cnt, bubble_cnt : statistics, live only when the macro
//                           PIPE_STAGE_STATS_EN is defined, else tied to 0
//
// state | meaning
// EMPTY | no payload held; out_valid=0, in_ready=1
// ONE   | main holds the head payload; out_valid=1, in_ready=1
// FULL  | main holds head, skid holds next; out_valid=1, in_ready=0
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = PAYLOAD_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    pipe_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q, skid_q;
    logic             in_fire, out_fire;
    logic             load_main, main_from_skid, load_skid;

    // Handshake outputs are pure decodes of the state register.
    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != FULL);
    assign out_data  = main_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d   = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (in_fire) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d        = ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush drops everything but leaves the data registers untouched.
        if (flush) begin
            state_d        = EMPTY;
            load_main      = 1'b0;
            main_from_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_main) begin
                main_q <= main_from_skid ? skid_q : in_data;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .en    (out_valid & ~out_ready),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .en    (~out_valid),
        .count (bubble_cnt)
    );
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam int W  = 37;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, out_ready;
    logic [W-1:0]  in_data;
    logic          in_ready, out_valid;
    logic [W-1:0]  out_data;
    logic [CW-1:0] stall_cnt, bubble_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: an ordered queue of held payloads (at most two) plus
    // the value last presented at the head, which the output keeps showing
    // after the queue drains or is flushed.
    logic [W-1:0] mq[$];
    logic [W-1:0] m_hold;
    int           m_stall, m_bubble;

    pipe_stage_reg #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int stat_exp(input int v);
`ifdef PIPE_STAGE_STATS_EN
        return (v > 15) ? 15 : v;
`else
        return 0 * v;
`endif
    endfunction

    // Advance one clock with the inputs currently driven, update the model,
    // then compare all outputs with the model 1 time unit after the edge.
    task automatic tick();
        bit m_in_fire, m_out_fire;
        m_in_fire  = in_valid && (mq.size() < 2);
        m_out_fire = (mq.size() > 0) && out_ready;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_hold   = '0;
            m_stall  = 0;
            m_bubble = 0;
        end else begin
            if (mq.size() == 0) m_bubble++;
            else if (!out_ready) m_stall++;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_out_fire) void'(mq.pop_front());
                if (m_in_fire) mq.push_back(in_data);
            end
            if (mq.size() > 0) m_hold = mq[0];
        end
        #1;
        check("model out_valid", 64'(out_valid), 64'(mq.size() > 0));
        check("model in_ready", 64'(in_ready), 64'(mq.size() < 2));
        check("model out_data", 64'(out_data), 64'(m_hold));
        check("model stall_cnt", 64'(stall_cnt), 64'(stat_exp(m_stall)));
        check("model bubble_cnt", 64'(bubble_cnt), 64'(stat_exp(m_bubble)));
    endtask

    task automatic drive(input logic r, input logic f, input logic iv,
                         input logic [W-1:0] d, input logic orr);
        rst_n     = r;
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = orr;
    endtask

    typedef struct {
        logic         rst_n;
        logic         flush;
        logic         in_valid;
        logic [W-1:0] in_data;
        logic         out_ready;
        logic         exp_ov;
        logic         exp_ir;
        logic [W-1:0] exp_od;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic f, input logic iv,
                                input logic [W-1:0] d, input logic orr,
                                input logic ov, input logic ir, input logic [W-1:0] od);
        vec_t v;
        v.rst_n = r; v.flush = f; v.in_valid = iv; v.in_data = d; v.out_ready = orr;
        v.exp_ov = ov; v.exp_ir = ir; v.exp_od = od;
        return v;
    endfunction

    initial begin
        logic [63:0] rnd;

        // Reset held for two edges with a payload offered.
        vecs.push_back(mk(0, 0, 1, 37'h1_2345_6789, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 37'h1_2345_6789, 0, 0, 1, 0));
        // Streaming 1..8, one cycle behind the input.
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(1, 0, 1, W'(i), 1, 1, 1, W'(i)));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, 8));
        // Backpressure: A then B fill the stage, C is refused, then drain.
        vecs.push_back(mk(1, 0, 1, 'hA, 0, 1, 1, 'hA));
        vecs.push_back(mk(1, 0, 1, 'hB, 0, 1, 0, 'hA));
        vecs.push_back(mk(1, 0, 1, 'hC, 0, 1, 0, 'hA));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 1, 'hB));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, 'hB));
        // Flush while FULL with a new payload offered.
        vecs.push_back(mk(1, 0, 1, 'h11, 0, 1, 1, 'h11));
        vecs.push_back(mk(1, 0, 1, 'h22, 0, 1, 0, 'h11));
        vecs.push_back(mk(1, 1, 1, 'h33, 1, 0, 1, 'h11));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, 'h11));
        // Simultaneous in_fire and out_fire in ONE.
        vecs.push_back(mk(1, 0, 1, 'h44, 0, 1, 1, 'h44));
        vecs.push_back(mk(1, 0, 1, 'h55, 1, 1, 1, 'h55));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 'h55));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, 'h55));
        // Reset while FULL beats flush and handshakes.
        vecs.push_back(mk(1, 0, 1, 'h66, 0, 1, 1, 'h66));
        vecs.push_back(mk(1, 0, 1, 'h77, 0, 1, 0, 'h66));
        vecs.push_back(mk(0, 1, 1, 'h88, 1, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0));

        drive(0, 0, 0, 0, 0);
        #2;
        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].flush, vecs[i].in_valid,
                  vecs[i].in_data, vecs[i].out_ready);
            tick();
            check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vecs[i].exp_ov));
            check($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(vecs[i].exp_ir));
            check($sformatf("vec%0d out_data", i), 64'(out_data), 64'(vecs[i].exp_od));
            if (i == 1) begin
                check("reset stall_cnt", 64'(stall_cnt), 64'd0);
                check("reset bubble_cnt", 64'(bubble_cnt), 64'd0);
            end
        end

        // Statistics: one bubble cycle while loading, then 20 stall cycles.
        drive(0, 0, 0, 0, 0); tick();
        drive(1, 0, 1, 'h5, 0); tick();
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) tick();
`ifdef PIPE_STAGE_STATS_EN
        check("stats stall saturated", 64'(stall_cnt), 64'd15);
        check("stats bubble", 64'(bubble_cnt), 64'd1);
        drive(1, 1, 0, 0, 0); tick();
        check("stats stall kept over flush", 64'(stall_cnt), 64'd15);
        check("stats bubble after flush", 64'(bubble_cnt), 64'd1);
`else
        check("stats stall off", 64'(stall_cnt), 64'd0);
        check("stats bubble off", 64'(bubble_cnt), 64'd0);
        drive(1, 1, 0, 0, 0); tick();
        check("stats stall off after flush", 64'(stall_cnt), 64'd0);
        check("stats bubble off after flush", 64'(bubble_cnt), 64'd0);
`endif

        // Randomized traffic against the queue model.
        for (int i = 0; i < 3000; i++) begin
            rnd = {$urandom(), $urandom()};
            drive(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 2) != 0),
                  rnd[W-1:0],
                  ($urandom_range(0, 2) != 0));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipe_stage_reg
